// File: rtl/fir_uart_tx.sv
// fir_uart_tx: byte-stream UART transmitter (8N1 or 8N2) with a small input FIFO.
// Bytes arrive on a valid/ready slave port, are queued in push order, and are
// serialised LSB first onto a registered, idle-high serial line. Consecutive
// frames are sent gaplessly while tx_en is high and the FIFO has data.
//
// Parameter ranges the logic relies on:
//   CLKS_PER_BIT >= 2, FIFO_DEPTH a power of two >= 2, STOP_BITS in {1, 2}.
module fir_uart_tx #(
  parameter int CLKS_PER_BIT = 4167,
  parameter int FIFO_DEPTH   = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                        axis_clk,
  input  logic                        axis_rst_n,
  input  logic                        s_tvalid,
  input  logic [7:0]                  s_tdata,
  output logic                        s_tready,
  input  logic                        tx_en,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic [15:0]                 frames_sent
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // FSM and serialiser state
  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_idx_q, bit_idx_d;   // data bit index in DATA, stop bit index in STOP
  logic [7:0]    shift_q, shift_d;       // bit 0 is always the bit currently on the line in DATA
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic [15:0]   frames_sent_q, frames_sent_d;

  // FIFO state
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic push;
  logic pop;
  logic can_start;
  logic baud_last;

  assign s_tready    = (count_q != DEPTH_C);
  assign push        = s_tvalid & s_tready;
  assign can_start   = tx_en & (count_q != '0);
  assign baud_last   = (baud_q == BAUD_LAST);

  assign tx          = tx_q;
  assign busy        = busy_q;
  assign fifo_count  = count_q;
  assign frames_sent = frames_sent_q;

  // FIFO storage: written on an accepted push, no reset needed since the
  // pointers and count define which entries are valid.
  always_ff @(posedge axis_clk) begin
    if (push) begin
      mem[wr_ptr_q] <= s_tdata;
    end
  end

  // State registers; reset forces the line high at once and empties the FIFO.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_q       <= IDLE;
      baud_q        <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      tx_q          <= 1'b1;
      busy_q        <= 1'b0;
      frames_sent_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      baud_q        <= baud_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      tx_q          <= tx_d;
      busy_q        <= busy_d;
      frames_sent_q <= frames_sent_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  // Next-state logic: frame sequencing, byte pop, and FIFO pointer/count update.
  always_comb begin
    state_d       = state_q;
    baud_d        = baud_q;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    tx_d          = tx_q;
    busy_d        = busy_q;
    frames_sent_d = frames_sent_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    pop           = 1'b0;

    case (state_q)
      IDLE: begin
        if (can_start) begin
          pop       = 1'b1;
          shift_d   = mem[rd_ptr_q];
          tx_d      = 1'b0;
          busy_d    = 1'b1;
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = START;
        end
      end

      START: begin
        if (baud_last) begin
          baud_d    = '0;
          bit_idx_d = '0;
          tx_d      = shift_q[0];
          state_d   = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = '0;
            tx_d      = 1'b1;
            state_d   = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      STOP: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_idx_q == STOP_LAST) begin
            // Last stop-bit cycle: the frame is complete. Chain straight into
            // the next start bit when allowed so frames stay back-to-back.
            frames_sent_d = frames_sent_q + 16'd1;
            bit_idx_d     = '0;
            if (can_start) begin
              pop     = 1'b1;
              shift_d = mem[rd_ptr_q];
              tx_d    = 1'b0;
              state_d = START;
            end else begin
              busy_d  = 1'b0;
              state_d = IDLE;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // Pointers wrap naturally because the depth is a power of two. A pop only
    // happens with count != 0, so a same-edge push never overwrites the entry
    // being read.
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

endmodule

// File: tb/tb_fir_uart_tx.sv
// tb_fir_uart_tx: two transmitter instances (1 and 2 stop bits) driven by
// directed scenarios followed by random traffic. A frame-level model (byte
// queue plus a per-frame cycle position) predicts every output each cycle; a
// line decoder recovers bytes, frame spacing and stop-level length from tx.
module tb_fir_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      rst_n;
  logic [1:0]      vld;
  logic [1:0]      en;
  logic [1:0][7:0] dat;

  logic [1:0]       rdy_w;
  logic [1:0]       tx_w;
  logic [1:0]       busy_w;
  logic [1:0][2:0]  cnt_w;
  logic [1:0][15:0] fs_w;

  fir_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .STOP_BITS(1)) dut0 (
    .axis_clk    (clk),
    .axis_rst_n  (rst_n[0]),
    .s_tvalid    (vld[0]),
    .s_tdata     (dat[0]),
    .s_tready    (rdy_w[0]),
    .tx_en       (en[0]),
    .tx          (tx_w[0]),
    .busy        (busy_w[0]),
    .fifo_count  (cnt_w[0]),
    .frames_sent (fs_w[0])
  );

  fir_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .STOP_BITS(2)) dut1 (
    .axis_clk    (clk),
    .axis_rst_n  (rst_n[1]),
    .s_tvalid    (vld[1]),
    .s_tdata     (dat[1]),
    .s_tready    (rdy_w[1]),
    .tx_en       (en[1]),
    .tx          (tx_w[1]),
    .busy        (busy_w[1]),
    .fifo_count  (cnt_w[1]),
    .frames_sent (fs_w[1])
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Behavioural model: pending bytes, frame in flight and its cycle position.
  logic [7:0]  mf [2][8];
  int          msz [2];
  bit          mact [2];
  int          mcnt [2];
  logic [7:0]  mbyte [2];
  logic [15:0] mfs [2];

  // Line decoder state and records.
  bit         rx_on [2];
  int         rx_t [2];
  logic [7:0] rx_b [2];
  int         hrun [2];
  int         last_start [2];
  logic [7:0] rxd [2][16];
  int         rxn [2];
  int         gap [2][16];
  int         run [2][16];
  int         stn [2];

  logic [9:0] s1_seq;
  logic [7:0] s2_bytes [5];
  bit         seen_low;

  function automatic int stop_of(input int k);
    return (k == 0) ? 1 : 2;
  endfunction

  function automatic logic exp_tx(input int k);
    int pos;
    if (!mact[k]) return 1'b1;
    pos = mcnt[k] / CPB;
    if (pos == 0) return 1'b0;
    if (pos <= 8) return mbyte[k][pos-1];
    return 1'b1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // One clock edge of the model, using the inputs held stable across the edge.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int sz0;
      if (!rst_n[k]) begin
        msz[k]  = 0;
        mact[k] = 1'b0;
        mcnt[k] = 0;
        mfs[k]  = '0;
      end else begin
        sz0 = msz[k];
        if (mact[k]) begin
          if (mcnt[k] == (9 + stop_of(k)) * CPB - 1) begin
            mfs[k]  = mfs[k] + 16'd1;
            mact[k] = 1'b0;
          end else begin
            mcnt[k]++;
          end
        end
        if (!mact[k] && en[k] && sz0 != 0) begin
          mbyte[k] = mf[k][0];
          for (int i = 0; i < 7; i++) mf[k][i] = mf[k][i+1];
          msz[k]--;
          mact[k] = 1'b1;
          mcnt[k] = 0;
        end
        if (vld[k] && sz0 != DEPTH) begin
          mf[k][msz[k]] = dat[k];
          msz[k]++;
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      if (!rst_n[k]) begin
        check($sformatf("rst_tx%0d", k),    tx_w[k],   1);
        check($sformatf("rst_busy%0d", k),  busy_w[k], 0);
        check($sformatf("rst_count%0d", k), cnt_w[k],  0);
        check($sformatf("rst_frames%0d", k), fs_w[k],  0);
        check($sformatf("rst_ready%0d", k), rdy_w[k],  1);
      end else begin
        check($sformatf("tx%0d", k),     tx_w[k],   exp_tx(k));
        check($sformatf("busy%0d", k),   busy_w[k], mact[k]);
        check($sformatf("count%0d", k),  cnt_w[k],  msz[k]);
        check($sformatf("ready%0d", k),  rdy_w[k],  msz[k] != DEPTH);
        check($sformatf("frames%0d", k), fs_w[k],   mfs[k]);
      end
    end
  endtask

  // Decode the serial line by mid-bit sampling, recording frame spacing.
  task automatic rx_step(input int k);
    logic line;
    line = tx_w[k];
    if (!rst_n[k]) begin
      rx_on[k]      = 1'b0;
      hrun[k]       = 0;
      last_start[k] = -1;
      return;
    end
    if (!rx_on[k]) begin
      if (!line) begin
        if (stn[k] < 16) begin
          gap[k][stn[k]] = (last_start[k] < 0) ? -1 : cyc - last_start[k];
          run[k][stn[k]] = hrun[k];
        end
        stn[k]++;
        last_start[k] = cyc;
        rx_on[k]      = 1'b1;
        rx_t[k]       = 0;
      end
    end else begin
      rx_t[k]++;
      if (rx_t[k] >= CPB && rx_t[k] < 9 * CPB && (rx_t[k] % CPB) == CPB / 2)
        rx_b[k][rx_t[k] / CPB - 1] = line;
      if (rx_t[k] == 9 * CPB + CPB / 2) begin
        check($sformatf("rx_stop%0d", k), line, 1);
        if (rxn[k] < 16) rxd[k][rxn[k]] = rx_b[k];
        rxn[k]++;
        rx_on[k] = 1'b0;
      end
    end
    if (line) hrun[k]++;
    else hrun[k] = 0;
  endtask

  task automatic rx_clear(input int k);
    rxn[k]        = 0;
    stn[k]        = 0;
    last_start[k] = -1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    compare_all();
    rx_step(0);
    rx_step(1);
  endtask

  initial begin
    rst_n = 2'b00;
    vld   = 2'b00;
    en    = 2'b00;
    dat   = '0;
    for (int k = 0; k < 2; k++) begin
      msz[k] = 0; mact[k] = 1'b0; mcnt[k] = 0; mfs[k] = '0; mbyte[k] = '0;
      rx_on[k] = 1'b0; rx_t[k] = 0; rx_b[k] = '0; hrun[k] = 0;
      rx_clear(k);
    end
    s1_seq   = 10'b11_0100_1010;
    s2_bytes = '{8'h00, 8'h5A, 8'hBF, 8'h01, 8'h7E};

    repeat (3) tick();
    rst_n = 2'b11;
    tick();

    // Scenario 1: single 0xA5 frame, exact line waveform.
    rx_clear(0);
    en[0] = 1'b1; vld[0] = 1'b1; dat[0] = 8'hA5;
    tick();
    vld[0] = 1'b0;
    check("s1_tx_at_push", tx_w[0], 1);
    check("s1_count_at_push", cnt_w[0], 1);
    for (int i = 0; i < 40; i++) begin
      tick();
      check($sformatf("s1_tx_c%0d", i), tx_w[0], s1_seq[i/4]);
    end
    check("s1_busy_last_cycle", busy_w[0], 1);
    tick();
    check("s1_busy_after", busy_w[0], 0);
    check("s1_frames", fs_w[0], 1);
    check("s1_rx_count", rxn[0], 1);
    check("s1_rx_byte", rxd[0][0], 8'hA5);

    // Scenarios 2 and 3: fill while disabled, drop on full, then gapless drain
    // with a push landing on the pop edge at count=1.
    en[0] = 1'b0;
    rx_clear(0);
    for (int j = 0; j < 4; j++) begin
      vld[0] = 1'b1; dat[0] = s2_bytes[j];
      tick();
    end
    check("s2_ready_full", rdy_w[0], 0);
    check("s2_count_full", cnt_w[0], 4);
    dat[0] = 8'hFF;
    tick();
    vld[0] = 1'b0;
    check("s2_count_after_drop", cnt_w[0], 4);
    en[0] = 1'b1;
    repeat (120) tick();
    check("s3_count_before", cnt_w[0], 1);
    vld[0] = 1'b1; dat[0] = 8'h7E;
    tick();
    vld[0] = 1'b0;
    check("s3_count_same_edge", cnt_w[0], 1);
    repeat (85) tick();
    check("s2_rx_count", rxn[0], 5);
    for (int j = 0; j < 5; j++) check($sformatf("s2_rx_byte%0d", j), rxd[0][j], s2_bytes[j]);
    for (int j = 1; j < 5; j++) check($sformatf("s2_gap%0d", j), gap[0][j], 40);
    check("s2_frames", fs_w[0], 6);

    // Scenario 4: asynchronous reset in the middle of data bit 3 of 0x00.
    vld[0] = 1'b1; dat[0] = 8'h00;
    tick();
    vld[0] = 1'b0;
    repeat (18) tick();
    check("s4_tx_bit3", tx_w[0], 0);
    #2;
    rst_n[0] = 1'b0;
    #1;
    check("s4_tx_async", tx_w[0], 1);
    check("s4_busy_async", busy_w[0], 0);
    check("s4_count_async", cnt_w[0], 0);
    check("s4_frames_async", fs_w[0], 0);
    repeat (3) tick();
    rst_n[0] = 1'b1;
    seen_low = 1'b0;
    repeat (30) begin
      tick();
      if (!tx_w[0]) seen_low = 1'b1;
    end
    check("s4_quiet_after_reset", seen_low, 0);
    check("s4_busy_after_reset", busy_w[0], 0);

    // Scenario 5: two stop bits, back-to-back 0x3C, 0xC3.
    rx_clear(1);
    en[1] = 1'b1; vld[1] = 1'b1; dat[1] = 8'h3C;
    tick();
    dat[1] = 8'hC3;
    tick();
    vld[1] = 1'b0;
    repeat (100) tick();
    check("s5_rx_count", rxn[1], 2);
    check("s5_rx_byte0", rxd[1][0], 8'h3C);
    check("s5_rx_byte1", rxd[1][1], 8'hC3);
    check("s5_period", gap[1][1], 44);
    check("s5_stop_level", run[1][1], 8);
    check("s5_frames", fs_w[1], 2);

    // Scenario 6: counter wrap, starting from a preloaded 0xFFFF.
    force dut0.frames_sent_q = 16'hFFFF;
    #1;
    release dut0.frames_sent_q;
    mfs[0] = 16'hFFFF;
    check("s6_preload", fs_w[0], 16'hFFFF);
    vld[0] = 1'b1; dat[0] = 8'h55;
    tick();
    vld[0] = 1'b0;
    repeat (45) tick();
    check("s6_wrap", fs_w[0], 0);
    check("s6_busy", busy_w[0], 0);

    // Random traffic on both instances, with rare one-cycle resets.
    repeat (4000) begin
      for (int k = 0; k < 2; k++) begin
        rst_n[k] = ($urandom_range(0, 1999) != 0);
        vld[k]   = ($urandom_range(0, 5) == 0);
        dat[k]   = 8'($urandom);
        if ($urandom_range(0, 79) == 0) en[k] = ~en[k];
      end
      tick();
    end
    rst_n = 2'b11;
    vld   = 2'b00;
    en    = 2'b11;
    repeat (200) tick();
    check("end_idle0", busy_w[0], 0);
    check("end_idle1", busy_w[1], 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
